// File: rtl/kgp_pkg.sv
// Shared KGP-RISC control definitions: opcodes, program_counter commands,
// sequencer state encoding and opcode classification helpers.
package kgp_pkg;

    localparam logic [5:0] OP_ALU_R = 6'h00;
    localparam logic [5:0] OP_ALU_I = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_JR    = 6'h04;
    localparam logic [5:0] OP_BZ    = 6'h05;
    localparam logic [5:0] OP_BNZ   = 6'h06;
    localparam logic [5:0] OP_BCY   = 6'h07;
    localparam logic [5:0] OP_BNEG  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h10;
    localparam logic [5:0] OP_SW    = 6'h11;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] PC_INC  = 4'b0000;
    localparam logic [3:0] PC_REG  = 4'b0001;
    localparam logic [3:0] PC_JUMP = 4'b0010;
    localparam logic [3:0] PC_HOLD = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Anything outside this set decodes as an illegal instruction and retires as a NOP.
    function automatic logic op_known(input logic [5:0] op);
        return op inside {OP_ALU_R, OP_ALU_I, OP_J, OP_JAL, OP_JR, OP_BZ, OP_BNZ,
                          OP_BCY, OP_BNEG, OP_LW, OP_SW, OP_HALT};
    endfunction

    function automatic logic op_writes_reg(input logic [5:0] op);
        return op inside {OP_ALU_R, OP_ALU_I, OP_LW, OP_JAL};
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Resolves the program_counter command for the write-back cycle from the
// latched opcode and the live condition flags.
module branch_resolve
    import kgp_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    input  logic       flag_sign,
    output logic [3:0] pc_cmd
);

    always_comb begin
        pc_cmd = PC_INC;
        case (opcode)
            OP_J, OP_JAL: pc_cmd = PC_JUMP;
            OP_JR:        pc_cmd = PC_REG;
            OP_BZ:        if (flag_zero)  pc_cmd = PC_JUMP;
            OP_BNZ:       if (!flag_zero) pc_cmd = PC_JUMP;
            OP_BCY:       if (flag_carry) pc_cmd = PC_JUMP;
            OP_BNEG:      if (flag_sign)  pc_cmd = PC_JUMP;
            default:      pc_cmd = PC_INC;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/execute/memory/write-back sequencer; the single
// driver of pc_control, issuing one PC update per retired instruction.
module pc_sequencer
    import kgp_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ir,
    output logic                alu_start,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    input  logic                flag_zero,
    input  logic                flag_carry,
    input  logic                flag_sign,
    output logic                reg_we,
    output logic [3:0]          pc_control,
    output logic                halted,
    output logic                illegal_instr,
    output logic [RETIRE_W-1:0] retired,
    output state_t              dbg_state
);

    state_t     state;
    logic [5:0] op;
    logic [3:0] wb_pc_cmd;

    assign op        = ir[31:26];
    assign dbg_state = state;

    // Handshake: a req stays high from the first cycle of FETCH/MEM until the
    // cycle its ack is seen (inclusive); the state advances on that edge, so
    // req drops the following cycle. An ack outside FETCH/MEM is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ir      <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE:   if (run) state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_HALT)   state <= S_HALT;
                    else if (!op_known(op)) state <= S_WB;
                    else                 state <= S_EXEC;
                end
                S_EXEC:   state <= (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
                S_MEM:    if (dmem_ack) state <= S_WB;
                S_WB: begin
                    retired <= retired + RETIRE_W'(1);
                    state   <= run ? S_FETCH : S_IDLE;
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    branch_resolve u_branch_resolve (
        .opcode     (op),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_sign  (flag_sign),
        .pc_cmd     (wb_pc_cmd)
    );

    // Outside write-back the program counter is always told to hold.
    assign pc_control    = (state == S_WB) ? wb_pc_cmd : PC_HOLD;
    assign imem_req      = (state == S_FETCH);
    assign dmem_req      = (state == S_MEM);
    assign dmem_we       = (state == S_MEM) && (op == OP_SW);
    assign alu_start     = (state == S_EXEC) && (op == OP_ALU_R || op == OP_ALU_I);
    assign reg_we        = (state == S_WB) && op_writes_reg(op);
    assign illegal_instr = (state == S_DECODE) && !op_known(op);
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-instruction cycle model fills an
// expected queue that is compared against the DUT outputs every cycle.
module tb_pc_sequencer;
    import kgp_pkg::*;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, run, imem_ack, dmem_ack;
    logic          flag_zero, flag_carry, flag_sign;
    logic [31:0]   imem_rdata;
    logic          imem_req, alu_start, dmem_req, dmem_we, reg_we;
    logic          halted, illegal_instr;
    logic [31:0]   ir;
    logic [3:0]    pc_control;
    logic [RW-1:0] retired;
    state_t        dbg_state;

    pc_sequencer #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .alu_start(alu_start),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_sign(flag_sign),
        .reg_we(reg_we), .pc_control(pc_control), .halted(halted),
        .illegal_instr(illegal_instr), .retired(retired), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [46:0] exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          dmem_cnt = 0;
    logic [3:0]  m_ret = '0;
    logic [31:0] m_ir = '0;

    function automatic logic [46:0] pack(input logic req, input logic dreq, input logic dwe,
                                         input logic alu, input logic rwe, input logic ill,
                                         input logic hlt, input logic [3:0] pc);
        return {req, dreq, dwe, alu, rwe, ill, hlt, pc, m_ret, m_ir};
    endfunction

    // Program-counter command expected in write-back, straight from the ISA rules.
    function automatic logic [3:0] exp_pc(input logic [5:0] op, input logic z,
                                          input logic c, input logic s);
        if (op == 6'h02 || op == 6'h03) return 4'b0010;
        if (op == 6'h04)                return 4'b0001;
        if ((op == 6'h05 && z) || (op == 6'h06 && !z) ||
            (op == 6'h07 && c) || (op == 6'h08 && s)) return 4'b0010;
        return 4'b0000;
    endfunction

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [46:0] e, a;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (pc_control > 4'd3) begin
                n_mis++;
                $display("FAIL pc_range actual=%b expected<=0011 t=%0t", pc_control, $time);
            end
            if (dmem_req) dmem_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {imem_req, dmem_req, dmem_we, alu_start, reg_we, illegal_instr,
                     halted, pc_control, retired, ir};
                n_cmp++;
                if (a !== e) begin
                    n_mis++;
                    $display("FAIL out_vec actual=%h expected=%h t=%0t", a, e, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_flags();
        flag_zero  = 1'($urandom_range(0, 1));
        flag_carry = 1'($urandom_range(0, 1));
        flag_sign  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycle(input logic run_v);
        step();
        run = run_v; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 4'b0011));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input logic c, input logic s,
                             input int fw, input int mw, input logic run_after,
                             input int lit_ret, input int lit_pcv, input int lit_rwe);
        logic [31:0] word;
        logic        known, mem, rwe;
        word  = {op, 26'($urandom)};
        known = op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                           6'h07, 6'h08, 6'h10, 6'h11, 6'h3F};
        mem   = (op == 6'h10) || (op == 6'h11);
        rwe   = known && (op inside {6'h00, 6'h01, 6'h10, 6'h03});
        for (int i = 0; i <= fw; i++) begin
            step();
            run = 1'b1; dmem_ack = 1'b0; rand_flags();
            imem_ack   = (i == fw);
            imem_rdata = (i == fw) ? word : $urandom;
            exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 4'b0011));
            if (i == 0 && lit_ret >= 0) begin
                @(negedge clk);
                lit("retired_count", 32'(retired), 32'(lit_ret));
            end
        end
        m_ir = word;
        step();
        imem_ack = 1'b0; imem_rdata = $urandom; rand_flags();
        exp_q.push_back(pack(0, 0, 0, 0, 0, !known, 0, 4'b0011));
        if (op == 6'h3F) return;
        if (known) begin
            step();
            rand_flags();
            exp_q.push_back(pack(0, 0, 0, op == 6'h00 || op == 6'h01, 0, 0, 0, 4'b0011));
        end
        if (mem) begin
            for (int i = 0; i <= mw; i++) begin
                step();
                rand_flags();
                dmem_ack = (i == mw);
                exp_q.push_back(pack(0, 1, op == 6'h11, 0, 0, 0, 0, 4'b0011));
            end
        end
        step();
        dmem_ack = 1'b0; run = run_after;
        flag_zero = z; flag_carry = c; flag_sign = s;
        exp_q.push_back(pack(0, 0, 0, 0, rwe, 0, 0, exp_pc(op, z, c, s)));
        @(negedge clk);
        if (lit_pcv >= 0) lit("wb_pc_control", 32'(pc_control), 32'(lit_pcv));
        if (lit_rwe >= 0) lit("wb_reg_we", 32'(reg_we), 32'(lit_rwe));
        m_ret = m_ret + 4'd1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [5:0] pool[8];
        pool = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h10};
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = '0; flag_zero = 1'b0; flag_carry = 1'b0; flag_sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_state", 32'(dbg_state), 32'(S_IDLE));
        lit("reset_ir", ir, 32'h0);
        lit("reset_retired", 32'(retired), 32'h0);
        lit("reset_pc_control", 32'(pc_control), 32'h3);
        lit("reset_imem_req", 32'(imem_req), 32'h0);
        rst = 1'b1;
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 4'b0011));
        idle_cycle(1'b1);

        //         op     z  c  s  fw mw run ret pc  rwe
        run_instr(6'h00, 0, 0, 0, 0, 0, 1, 0,  0,  1);
        dmem_cnt = 0;
        run_instr(6'h10, 0, 0, 0, 0, 3, 1, 1,  0,  1);
        lit("lw_dmem_req_cycles", 32'(dmem_cnt), 32'd4);
        run_instr(6'h05, 1, 0, 0, 0, 0, 1, -1, 2, -1);
        run_instr(6'h05, 0, 1, 1, 0, 0, 1, -1, 0, -1);
        run_instr(6'h06, 1, 0, 0, 0, 0, 1, -1, 0, -1);
        run_instr(6'h06, 0, 0, 0, 0, 0, 1, -1, 2, -1);
        run_instr(6'h04, 1, 1, 1, 0, 0, 1, -1, 1, 0);
        run_instr(6'h03, 0, 0, 0, 0, 0, 1, -1, 2, 1);
        run_instr(6'h07, 0, 1, 0, 1, 0, 1, -1, 2, -1);
        run_instr(6'h08, 0, 0, 1, 0, 0, 1, -1, 2, -1);
        run_instr(6'h11, 0, 0, 0, 2, 1, 1, 10, 0, 0);
        run_instr(6'h02, 0, 0, 0, 0, 0, 1, -1, 2, 0);
        run_instr(6'h20, 1, 1, 1, 0, 0, 0, -1, 0, 0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        run_instr(6'h01, 0, 0, 0, 1, 0, 1, 13, 0, 1);
        for (int k = 0; k < 6; k++) begin
            run_instr(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, -1, -1, -1);
        end
        // 20 instructions retired on a 4-bit counter: it has wrapped to 4.
        lit("retired_wrapped", 32'(m_ret), 32'd4);

        // Reset dropped mid-fetch while the memory keeps acking.
        step();
        run = 1'b1; imem_ack = 1'b0;
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 4'b0011));
        step();
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 4'b0011));
        step();
        imem_ack = 1'b1; imem_rdata = $urandom;
        #2;
        rst = 1'b0;
        #1;
        lit("async_rst_imem_req", 32'(imem_req), 32'h0);
        lit("async_rst_state", 32'(dbg_state), 32'(S_IDLE));
        lit("async_rst_retired", 32'(retired), 32'h0);
        lit("async_rst_pc_control", 32'(pc_control), 32'h3);
        m_ret = '0;
        m_ir  = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 4'b0011));
        end
        step();
        rst = 1'b1; imem_ack = 1'b0; run = 1'b1;
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 4'b0011));

        // HALT is terminal whatever the inputs do afterwards.
        run_instr(6'h3F, 0, 0, 0, 1, 0, 1, 0, -1, -1);
        for (int k = 0; k < 20; k++) begin
            step();
            run = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            rand_flags();
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 1, 4'b0011));
        end
        @(negedge clk);
        lit("halt_halted", 32'(halted), 32'h1);
        lit("halt_pc_control", 32'(pc_control), 32'h3);
        #1;
        lit("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle control FSM that sequences the KGP-RISC program counter and the fetch/execute handshakes around it. It fetches an instruction over a req/ack port and decodes its opcode class. It steps the ALU and data-memory phases, then issues exactly one `pc_control` update per retired instruction. It sits between instruction memory, the register file/ALU and `program_counter`, and is the only driver of `pc_control`.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; leave IDLE when high.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  latched instruction register.
- `alu_start`  out  1  one-cycle pulse in EXEC for ALU-class instructions.
- `dmem_req`  out  1  data access request; `dmem_we`  out  1  write (SW).
- `dmem_ack`  in  1  data access complete.
- `flag_zero`, `flag_carry`, `flag_sign`  in  1 each  condition flags from the flag register.
- `reg_we`  out  1  register-file write strobe (WB only).
- `pc_control`  out  4  command to `program_counter`.
- `halted`  out  1  high in HALT.
- `illegal_instr`  out  1  one-cycle pulse in DECODE on an unknown opcode.
- `retired`  out  RETIRE_W  count of completed instructions, wrapping.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE -> FETCH when `run`=1. Otherwise stay.
- FETCH: `imem_req`=1. On `imem_ack`=1, load `ir`<=`imem_rdata` and go to DECODE. Otherwise stay with `imem_req` held.
- DECODE: classify `ir[31:26]`.
  - HALT (6'h3F) -> HALT.
  - Unknown opcode: pulse `illegal_instr`, treat as NOP, -> WB.
  - All others -> EXEC.
- EXEC: pulse `alu_start` for ALU_R (6'h00) and ALU_I (6'h01). LW (6'h10) and SW (6'h11) go to MEM. All others go to WB.
- MEM: `dmem_req`=1, `dmem_we`=(SW). On `dmem_ack` -> WB.
- WB: `reg_we`=1 for ALU_R, ALU_I, LW and JAL. Retire: `retired`+1. Drive the PC command, then -> FETCH, or -> IDLE if `run`=0.
- PC command in WB:
  - J (6'h02), JAL (6'h03): 4'b0010.
  - JR (6'h04): 4'b0001.
  - BZ (6'h05) if `flag_zero`, BNZ (6'h06) if !`flag_zero`, BCY (6'h07) if `flag_carry`, BNEG (6'h08) if `flag_sign`: 4'b0010.
  - Everything else, including untaken branches and illegal opcodes: 4'b0000.
- In every state other than WB, `pc_control`=4'b0011 (hold).
- Codes 4'b0100–4'b1111 are never driven; `program_counter` maps them to 32'hFFFFFFFF.
- JAL link: `wdata` is sampled in the WB cycle, so it equals the JAL's own address. The PC updates at the edge ending WB.
- HALT: terminal. `halted`=1, hold code, no requests. Exit only via reset.
- Flags are sampled combinationally in the WB cycle.

## Timing
- Reset (`rst`=0, asynchronous):
  - state IDLE, `ir`=0, `retired`=0, `pc_control`=4'b0011.
  - All other outputs 0.
  - Reset mid-FETCH/MEM drops the request immediately; a late ack after reset is ignored.
- `pc_control`, `imem_req`, `dmem_req`, `dmem_we`, `reg_we`, `alu_start`, `illegal_instr` and `halted` are Moore decodes of state plus latched `ir`.
- Instruction latency with zero-wait ack (ack in the first request cycle):
  - ALU / jump / branch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW / SW: 5 cycles.
  - Each wait cycle on an ack adds one cycle.
- Requests stay asserted until acked and are deasserted the cycle after the ack.
- `retired` wraps from all-ones to 0.

## Structure
- Shared package `kgp_pkg`:
  - opcode localparams.
  - PC command constants `PC_INC`=4'b0000, `PC_REG`=4'b0001, `PC_JUMP`=4'b0010, `PC_HOLD`=4'b0011.
  - state enum encoding.
- One sub-module, `branch_resolve`: combinational opcode+flags -> `pc_control` for the WB cycle.

## Test plan
- Reset, then `run`=1, ALU_R with immediate ack -> `pc_control` is 0011,0011,0011,0000 over 4 cycles; `reg_we`=1 only in cycle 4; `retired`=1.
- LW with `dmem_ack` delayed 3 cycles -> `dmem_req` high exactly 3 cycles plus the ack cycle, `dmem_we`=0, `pc_control`=0000 in WB; total 8 cycles.
- BZ with `flag_zero`=1 -> 0010 in WB; with `flag_zero`=0 -> 0000. BNZ gives the mirror result.
- JR -> 0001. JAL -> 0010 with `reg_we`=1 in the same cycle.
- Opcode 6'h20 -> `illegal_instr` pulse in DECODE and 0000 in WB. Opcode 6'h3F -> `halted`=1 and `pc_control`=0011 held for 20 cycles.
- Drop `rst` mid-FETCH with `imem_ack` pulsing -> `imem_req`=0 at once, state IDLE, `retired`=0, and the value 4'b0100 or above never appears on `pc_control`.
